program_counter_unit: RTL and testbench
=======================================

Name: program_counter_unit

Overview:
Program counter register for the single-issue MIPS datapath. It closes the loop with the PC adder: it drives PCResult into the adder and captures PCAddResult back on each clock edge. It also handles pipeline stall, branch/jump redirect with a one-deep pending-redirect buffer, and a post-reset startup hold for instruction-memory warm-up. A free-running fetch counter is provided for debug and CPI measurement.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and held during startup.
STARTUP_CYCLES, 2, number of rising edges after Reset deasserts before fetch starts; range 0..15.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
PCAddResult  input  32  sequential next PC (PCResult + 4) from PC adder
Stall  input  1  hazard unit freeze; PC holds while high
Redirect  input  1  single-cycle pulse: branch/jump taken
RedirectTarget  input  32  target address, valid when Redirect=1
PCResult  output  32  current PC, to instruction memory and PC adder
PCValid  output  1  high when PCResult is a real fetch address (RUN state)
RedirectPending  output  1  a redirect is buffered awaiting stall release
FetchCount  output  32  number of PC advances since reset
MisalignErr  output  1  sticky misaligned-target flag (optional feature)

Behaviour:
- Reset is asynchronous, active-high; one clock, Clk, all state on its rising edge.
- Reset values: PCResult=RESET_PC, PCValid=0 (1 if STARTUP_CYCLES=0), RedirectPending=0, pending target=0, FetchCount=0, MisalignErr=0, startup counter=0.
- Reset asserted mid-operation: all state returns to reset values immediately; any pending redirect is discarded.
- FSM states:
  - HOLD: startup counter increments each edge; PCResult held at RESET_PC; PCValid=0. Move to RUN on the edge where counter reaches STARTUP_CYCLES-1. With STARTUP_CYCLES=0, reset enters RUN directly.
  - RUN: PCValid=1. There is no return to HOLD except by Reset.
- Next-PC priority in RUN with Stall=0, one-cycle latency (new value visible after the edge):
  1. Redirect=1: load RedirectTarget and clear the pending buffer. A newer redirect overrides a buffered one.
  2. Otherwise, if pending: load the pending target and clear pending.
  3. Otherwise: load PCAddResult.
  - Each of these increments FetchCount by 1. FetchCount wraps 32'hFFFF_FFFF -> 0.
- RUN with Stall=1:
  - PCResult and FetchCount hold.
  - Redirect=1 writes RedirectTarget into the pending buffer and sets RedirectPending on the next edge. The last redirect wins.
- HOLD:
  - Redirect=1 is captured into the pending buffer, same as under a stall.
  - Stall is ignored; FetchCount does not count.
  - Pending is applied on the first RUN advance.
- RedirectPending is asserted exactly while the buffer is occupied. It clears on the edge that consumes the buffer.
- PCAddResult is used verbatim; no arithmetic is performed inside the block. A wrap from 32'hFFFF_FFFC to 0 comes from the adder and is accepted.

Optional Feature:
Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Any target loaded into PCResult or into the pending buffer has bits [1:0] forced to 2'b00.
  - If a Redirect arrives with RedirectTarget[1:0]!=0, MisalignErr is set on that edge. It stays set until Reset.
- Not defined:
  - Targets are loaded verbatim.
  - MisalignErr is tied to 0.
  - The port list is unchanged.

Test Plan:
- Reset pulse mid-cycle, RESET_PC=0, STARTUP_CYCLES=2 -> PCResult=0 and PCValid=0 immediately. PCValid rises after the 2nd edge. Subsequent edges with the adder looped give PC 4, 8, 12 and FetchCount 1, 2, 3.
- In RUN at PC=0x10, Redirect=1 with target 0x40, Stall=0 -> next PC=0x40, then 0x44. RedirectPending stays 0.
- PC=0x20, Stall=1 for 3 cycles, Redirect pulses with 0x80 then 0x90 during the stall -> PC held at 0x20, RedirectPending=1, FetchCount frozen. On release, PC=0x90, then 0x94.
- Pending=0x90 and a new Redirect 0xA0 on the stall-release cycle -> PC=0xA0 and pending cleared.
- FetchCount preset near wrap (run 2^32 cycles, or force 32'hFFFF_FFFF) -> next advance gives 0. Reset asserted while RedirectPending=1 -> pending cleared and PC=RESET_PC.
- PC_ALIGN_CHECK_EN defined, Redirect to 0x43 -> PC=0x40 and MisalignErr=1 sticky through later redirects. With the macro undefined, PC=0x43 and MisalignErr=0.

Source files
------------

// File: rtl/program_counter_unit.sv
// program_counter_unit: PC register for the single-issue MIPS datapath.
// Loops PCResult through the external PC adder, holds on Stall, buffers one
// pending branch/jump redirect, and holds at RESET_PC for STARTUP_CYCLES edges
// after reset while instruction memory warms up. FetchCount counts PC advances.
// Optional feature macro: PC_ALIGN_CHECK_EN (word-aligns targets, drives
// the sticky MisalignErr flag). Without it, targets load verbatim and
// MisalignErr is tied low.
module program_counter_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned STARTUP_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] PCResult,
    output logic        PCValid,
    output logic        RedirectPending,
    output logic [31:0] FetchCount,
    output logic        MisalignErr
);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Zero startup cycles means reset lands directly in RUN.
    localparam state_t     RESET_STATE = (STARTUP_CYCLES == 0) ? ST_RUN : ST_HOLD;
    localparam logic [3:0] LAST_COUNT  = (STARTUP_CYCLES == 0) ? 4'd0 : 4'(STARTUP_CYCLES - 1);

    // Target conditioning: word-aligned when the alignment check is built in.
    function automatic logic [31:0] align_target(input logic [31:0] target);
`ifdef PC_ALIGN_CHECK_EN
        return {target[31:2], 2'b00};
`else
        return target;
`endif
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  start_cnt_q, start_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        advance_s;

    // State register: FSM state, startup counter and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= RESET_STATE;
            start_cnt_q   <= 4'd0;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            start_cnt_q   <= start_cnt_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic: count startup edges in HOLD, then stay in RUN until reset.
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        case (state_q)
            ST_HOLD: begin
                start_cnt_d = start_cnt_q + 4'd1;
                if (start_cnt_q == LAST_COUNT) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Output logic: fetch addresses are real only in RUN.
    always_comb begin
        PCValid = 1'b0;
        case (state_q)
            ST_RUN:  PCValid = 1'b1;
            ST_HOLD: PCValid = 1'b0;
            default: PCValid = 1'b0;
        endcase
    end

    assign advance_s = (state_q == ST_RUN) && !Stall;

    // Next-PC selection: redirect beats pending beats sequential; otherwise buffer redirects.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        fetch_count_d = fetch_count_q;
        if (advance_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
            pend_valid_d  = 1'b0;
            if (Redirect) begin
                pc_d = align_target(RedirectTarget);
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = PCAddResult;
            end
        end else begin
            if (Redirect) begin
                pend_valid_d  = 1'b1;
                pend_target_d = align_target(RedirectTarget);
            end else begin
                pend_valid_d  = pend_valid_q;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_q | (Redirect & (RedirectTarget[1:0] != 2'b00));
        end
    end

    assign MisalignErr = misalign_q;
`else
    assign MisalignErr = 1'b0;
`endif

    assign PCResult        = pc_q;
    assign RedirectPending = pend_valid_q;
    assign FetchCount      = fetch_count_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench for program_counter_unit (RESET_PC=0, STARTUP_CYCLES=2).
// The PC adder is modelled by looping PCResult+4 back into PCAddResult.
module tb_program_counter_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] PCAddResult;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] PCResult;
    logic        PCValid;
    logic        RedirectPending;
    logic [31:0] FetchCount;
    logic        MisalignErr;

    int errors = 0;
    int checks = 0;

    program_counter_unit #(
        .RESET_PC       (32'h0000_0000),
        .STARTUP_CYCLES (2)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .PCAddResult     (PCAddResult),
        .Stall           (Stall),
        .Redirect        (Redirect),
        .RedirectTarget  (RedirectTarget),
        .PCResult        (PCResult),
        .PCValid         (PCValid),
        .RedirectPending (RedirectPending),
        .FetchCount      (FetchCount),
        .MisalignErr     (MisalignErr)
    );

    assign PCAddResult = PCResult + 32'd4;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_PC  = 32'h0000_0040;
    localparam logic        MIS_ERR = 1'b1;
`else
    localparam logic [31:0] MIS_PC  = 32'h0000_0043;
    localparam logic        MIS_ERR = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_pend;
        logic [31:0] exp_fc;
        logic        exp_merr;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic valid,
                             input logic pend, input logic [31:0] fc, input logic merr);
        check({tag, ".pc"},    PCResult, pc);
        check({tag, ".valid"}, {31'd0, PCValid}, {31'd0, valid});
        check({tag, ".pend"},  {31'd0, RedirectPending}, {31'd0, pend});
        check({tag, ".fc"},    FetchCount, fc);
        check({tag, ".merr"},  {31'd0, MisalignErr}, {31'd0, merr});
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample on the next falling edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] tg);
        Stall          = st;
        Redirect       = rd;
        RedirectTarget = tg;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        //         stall redir target         pc            valid pend fc      merr
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   32'h0000_0000, 1'b0, 1'b0, 32'd0,  1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   32'h0000_0000, 1'b1, 1'b0, 32'd0,  1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   32'h0000_0004, 1'b1, 1'b0, 32'd1,  1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   32'h0000_0008, 1'b1, 1'b0, 32'd2,  1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   32'h0000_000C, 1'b1, 1'b0, 32'd3,  1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   32'h0000_0010, 1'b1, 1'b0, 32'd4,  1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h40,  32'h0000_0040, 1'b1, 1'b0, 32'd5,  1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   32'h0000_0044, 1'b1, 1'b0, 32'd6,  1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h20,  32'h0000_0020, 1'b1, 1'b0, 32'd7,  1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h80,  32'h0000_0020, 1'b1, 1'b1, 32'd7,  1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h90,  32'h0000_0020, 1'b1, 1'b1, 32'd7,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,   32'h0000_0020, 1'b1, 1'b1, 32'd7,  1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   32'h0000_0090, 1'b1, 1'b0, 32'd8,  1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,   32'h0000_0094, 1'b1, 1'b0, 32'd9,  1'b0};
        vecs[14] = '{1'b1, 1'b1, 32'hB0,  32'h0000_0094, 1'b1, 1'b1, 32'd9,  1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'hA0,  32'h0000_00A0, 1'b1, 1'b0, 32'd10, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   32'h0000_00A4, 1'b1, 1'b0, 32'd11, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 32'h0,   32'h0000_00A4, 1'b1, 1'b0, 32'd11, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 32'h43,  MIS_PC,        1'b1, 1'b0, 32'd12, MIS_ERR};
        vecs[19] = '{1'b0, 1'b0, 32'h0,   MIS_PC + 32'd4, 1'b1, 1'b0, 32'd13, MIS_ERR};
        vecs[20] = '{1'b0, 1'b1, 32'h100, 32'h0000_0100, 1'b1, 1'b0, 32'd14, MIS_ERR};

        Reset          = 1'b0;
        Stall          = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 32'h0;

        // Asynchronous reset pulse away from any clock edge: outputs clear at once.
        #12;
        Reset = 1'b1;
        #1;
        check_all("reset", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].stall, vecs[i].redirect, vecs[i].target);
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                      vecs[i].exp_pend, vecs[i].exp_fc, vecs[i].exp_merr);
        end

        // Reset while a redirect is buffered discards it.
        step(1'b1, 1'b1, 32'h200);
        check_all("prerst", 32'h100, 1'b1, 1'b1, 32'd14, MIS_ERR);
        Stall    = 1'b0;
        Redirect = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check_all("midrst", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;

        // Redirect during HOLD is buffered; Stall is ignored; pending applies on first RUN advance.
        step(1'b1, 1'b1, 32'h300);
        check_all("hold1", 32'h0, 1'b0, 1'b1, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'h0);
        check_all("hold2", 32'h0, 1'b1, 1'b1, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        check_all("hold3", 32'h300, 1'b1, 1'b0, 32'd1, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        check_all("hold4", 32'h304, 1'b1, 1'b0, 32'd2, 1'b0);

        // FetchCount wrap: preset to all ones, next advance gives zero.
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        #1;
        step(1'b0, 1'b0, 32'h0);
        check_all("wrap", 32'h308, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        check_all("wrap2", 32'h30C, 1'b1, 1'b0, 32'd1, 1'b0);

        // PC adder wrap is accepted verbatim.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        check_all("adwr1", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd2, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        check_all("adwr2", 32'h0, 1'b1, 1'b0, 32'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
